// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and FSM state types for the memory responder.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  // Severity follows the encoding: DECERR > SLVERR > OKAY (EXOKAY is never produced).
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bundle: 32-bit data, 4-bit ID, 8-bit burst length.
interface axi4_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awid;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awid,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arburst, arid,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awid,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arlen, arsize, arburst, arid,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready
  );
endinterface

// File: rtl/axi4_burst_addr.sv
// Per-beat address step plus decode of word index and beat response.
module axi4_burst_addr
  import axi4_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [31:0]                  i_addr,
  input  logic [1:0]                   i_burst,
  input  logic [2:0]                   i_size,
  output logic [31:0]                  o_next_addr,
  output logic [$clog2(MEM_WORDS)-1:0] o_index,
  output logic [1:0]                   o_resp
);

  logic [31:0] w_offset;
  logic        w_in_range;
  logic        w_burst_err;

  always_comb begin
    w_offset    = i_addr - BASE_ADDR;
    // Byte-offset compare is equivalent to word index < MEM_WORDS, low bits ignored.
    w_in_range  = (i_addr >= BASE_ADDR) && (w_offset < (32'(MEM_WORDS) << 2));
    w_burst_err = !((i_burst == BURST_INCR) || (i_burst == BURST_FIXED)) ||
                  (i_size != SIZE_WORD);
    o_next_addr = (i_burst == BURST_INCR) ? i_addr + 32'd4 : i_addr;
    o_index     = w_offset[$clog2(MEM_WORDS)+1:2];
    if (!w_in_range) begin
      o_resp = RESP_DECERR;
    end else if (w_burst_err) begin
      o_resp = RESP_SLVERR;
    end else begin
      o_resp = RESP_OKAY;
    end
  end

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 responder over a MEM_WORDS x 32 word memory; independent read and write FSMs.
module axi4_mem_slave
  import axi4_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic   clk,
  input logic   reset,
  axi4_if.slave axi
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [31:0] r_mem [MEM_WORDS];

  // Write channel state
  wstate_e     r_wstate;
  logic [31:0] r_waddr;
  logic [7:0]  r_awlen;
  logic [2:0]  r_awsize;
  logic [1:0]  r_awburst;
  logic [3:0]  r_awid;
  logic [7:0]  r_wbeat;
  logic [1:0]  r_bacc;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic [3:0]  r_bid;

  logic [31:0]      w_wnext_addr;
  logic [IDX_W-1:0] w_widx;
  logic [1:0]       w_waddr_resp;
  logic             w_whs;
  logic             w_wlast_beat;
  logic [1:0]       w_wbeat_resp;
  logic [1:0]       w_bacc_next;
  logic             w_wr_en;

  // Read channel state
  rstate_e     r_rstate;
  logic [31:0] r_raddr;
  logic [7:0]  r_arlen;
  logic [2:0]  r_arsize;
  logic [1:0]  r_arburst;
  logic [7:0]  r_rbeat;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [3:0]  r_rid;
  logic        r_rlast;

  logic [31:0]      w_rsel_addr;
  logic [1:0]       w_rsel_burst;
  logic [2:0]       w_rsel_size;
  logic [31:0]      w_rnext_addr;
  logic [IDX_W-1:0] w_ridx;
  logic [1:0]       w_raddr_resp;
  logic [31:0]      w_rbeat_data;
  logic [7:0]       w_rbeat_nxt;
  logic             w_arhs;
  logic             w_rhs;

  axi4_burst_addr #(
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) u_waddr (
    .i_addr      (r_waddr),
    .i_burst     (r_awburst),
    .i_size      (r_awsize),
    .o_next_addr (w_wnext_addr),
    .o_index     (w_widx),
    .o_resp      (w_waddr_resp)
  );

  axi4_burst_addr #(
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) u_raddr (
    .i_addr      (w_rsel_addr),
    .i_burst     (w_rsel_burst),
    .i_size      (w_rsel_size),
    .o_next_addr (w_rnext_addr),
    .o_index     (w_ridx),
    .o_resp      (w_raddr_resp)
  );

  always_comb begin
    w_whs        = (r_wstate == W_DATA) && axi.wvalid && r_wready;
    w_wlast_beat = (r_wbeat == r_awlen);
    // wlast only grades the response; the beat count still ends the burst.
    w_wbeat_resp = resp_worst(w_waddr_resp,
                              (axi.wlast != w_wlast_beat) ? RESP_SLVERR : RESP_OKAY);
    w_bacc_next  = resp_worst(r_bacc, w_wbeat_resp);
    w_wr_en      = w_whs && !reset && (w_waddr_resp == RESP_OKAY);
  end

  always_comb begin
    w_arhs = (r_rstate == R_IDLE) && axi.arvalid && r_arready;
    w_rhs  = r_rvalid && axi.rready;
    // In idle the first beat is decoded straight from the AR channel.
    if (r_rstate == R_IDLE) begin
      w_rsel_addr  = axi.araddr;
      w_rsel_burst = axi.arburst;
      w_rsel_size  = axi.arsize;
    end else begin
      w_rsel_addr  = r_raddr;
      w_rsel_burst = r_arburst;
      w_rsel_size  = r_arsize;
    end
    w_rbeat_data = (w_raddr_resp == RESP_OKAY) ? r_mem[w_ridx] : 32'd0;
    w_rbeat_nxt  = r_rbeat + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (axi.wstrb[i]) begin
          r_mem[w_widx][8*i +: 8] <= axi.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate  <= W_IDLE;
      r_waddr   <= 32'd0;
      r_awlen   <= 8'd0;
      r_awsize  <= 3'd0;
      r_awburst <= 2'd0;
      r_awid    <= 4'd0;
      r_wbeat   <= 8'd0;
      r_bacc    <= RESP_OKAY;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bid     <= 4'd0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (axi.awvalid && r_awready) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_waddr   <= axi.awaddr;
            r_awlen   <= axi.awlen;
            r_awsize  <= axi.awsize;
            r_awburst <= axi.awburst;
            r_awid    <= axi.awid;
            r_wbeat   <= 8'd0;
            r_bacc    <= RESP_OKAY;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_whs) begin
            r_waddr <= w_wnext_addr;
            r_wbeat <= r_wbeat + 8'd1;
            r_bacc  <= w_bacc_next;
            if (w_wlast_beat) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_bacc_next;
              r_bid    <= r_awid;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate  <= R_IDLE;
      r_raddr   <= 32'd0;
      r_arlen   <= 8'd0;
      r_arsize  <= 3'd0;
      r_arburst <= 2'd0;
      r_rbeat   <= 8'd0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
      r_rresp   <= RESP_OKAY;
      r_rid     <= 4'd0;
      r_rlast   <= 1'b0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_arhs) begin
            r_arready <= 1'b0;
            r_raddr   <= w_rnext_addr;
            r_arlen   <= axi.arlen;
            r_arsize  <= axi.arsize;
            r_arburst <= axi.arburst;
            r_rbeat   <= 8'd0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rbeat_data;
            r_rresp   <= w_raddr_resp;
            r_rid     <= axi.arid;
            r_rlast   <= (axi.arlen == 8'd0);
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_rhs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_rbeat <= w_rbeat_nxt;
              r_raddr <= w_rnext_addr;
              r_rdata <= w_rbeat_data;
              r_rresp <= w_raddr_resp;
              r_rlast <= (w_rbeat_nxt == r_arlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign axi.awready = r_awready;
  assign axi.wready  = r_wready;
  assign axi.bvalid  = r_bvalid;
  assign axi.bresp   = r_bresp;
  assign axi.bid     = r_bid;
  assign axi.arready = r_arready;
  assign axi.rvalid  = r_rvalid;
  assign axi.rdata   = r_rdata;
  assign axi.rresp   = r_rresp;
  assign axi.rid     = r_rid;
  assign axi.rlast   = r_rlast;

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Randomized and directed bench for axi4_mem_slave against a word-array reference model.
module tb_axi4_mem_slave;
  import axi4_pkg::*;

  localparam int unsigned MEM_WORDS = 1024;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;

  axi4_if u_axi ();

  axi4_mem_slave #(
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .axi   (u_axi)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] ref_mem [MEM_WORDS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [1:0] burst,
                                            input int beat);
    return (burst == 2'b01) ? start + 32'(4 * beat) : start;
  endfunction

  function automatic bit in_map(input logic [31:0] a);
    longint unsigned off;
    if (a < BASE_ADDR) return 1'b0;
    off = 64'(a - BASE_ADDR);
    return (off / 4) < 64'(MEM_WORDS);
  endfunction

  function automatic bit bad_burst(input logic [1:0] burst, input logic [2:0] size);
    return !(burst == 2'b00 || burst == 2'b01) || size != 3'd2;
  endfunction

  function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
    int sa, sb;
    sa = (a == 2'b11) ? 2 : (a == 2'b10) ? 1 : 0;
    sb = (b == 2'b11) ? 2 : (b == 2'b10) ? 1 : 0;
    return (sb > sa) ? b : a;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id,
                           input logic [31:0] data[$], input logic [3:0] strb[$],
                           input int wlast_beat, input int b_delay);
    logic [1:0]  exp_resp;
    logic [31:0] a, d, idx;
    logic [3:0]  s;
    int n;
    exp_resp = 2'b00;
    @(negedge clk);
    u_axi.awvalid = 1'b1; u_axi.awaddr = addr; u_axi.awlen = len;
    u_axi.awburst = burst; u_axi.awsize = size; u_axi.awid = id;
    n = 0;
    while (!u_axi.awready && n < 100) begin @(negedge clk); n++; end
    if (!u_axi.awready) begin
      check_eq("aw_timeout", 32'd0, 32'd1); u_axi.awvalid = 1'b0; return;
    end
    @(negedge clk);
    u_axi.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      d = data[i]; s = strb[i];
      u_axi.wvalid = 1'b1; u_axi.wdata = d; u_axi.wstrb = s; u_axi.wlast = (i == wlast_beat);
      n = 0;
      while (!u_axi.wready && n < 100) begin @(negedge clk); n++; end
      if (!u_axi.wready) begin
        check_eq("w_timeout", 32'd0, 32'd1); u_axi.wvalid = 1'b0; return;
      end
      a = beat_addr(addr, burst, i);
      if (!in_map(a)) begin
        exp_resp = worse(exp_resp, 2'b11);
      end else if (bad_burst(burst, size)) begin
        exp_resp = worse(exp_resp, 2'b10);
      end else begin
        idx = (a - BASE_ADDR) >> 2;
        for (int k = 0; k < 4; k++) if (s[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
      end
      if ((i == wlast_beat) != (i == int'(len))) exp_resp = worse(exp_resp, 2'b10);
      @(negedge clk);
    end
    u_axi.wvalid = 1'b0; u_axi.wlast = 1'b0;
    n = 0;
    while (!u_axi.bvalid && n < 100) begin @(negedge clk); n++; end
    if (!u_axi.bvalid) begin check_eq("b_timeout", 32'd0, 32'd1); return; end
    repeat (b_delay) begin
      @(negedge clk);
      check_eq("b_held", 32'(u_axi.bvalid), 32'd1);
    end
    check_eq("bresp", 32'(u_axi.bresp), 32'(exp_resp));
    check_eq("bid", 32'(u_axi.bid), 32'(id));
    u_axi.bready = 1'b1;
    @(negedge clk);
    u_axi.bready = 1'b0;
    check_eq("b_drop", 32'(u_axi.bvalid), 32'd0);
  endtask

  task automatic ar_start(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] id, output bit ok);
    int n;
    ok = 1'b0;
    @(negedge clk);
    u_axi.arvalid = 1'b1; u_axi.araddr = addr; u_axi.arlen = len;
    u_axi.arburst = burst; u_axi.arsize = size; u_axi.arid = id;
    n = 0;
    while (!u_axi.arready && n < 100) begin @(negedge clk); n++; end
    if (!u_axi.arready) begin
      check_eq("ar_timeout", 32'd0, 32'd1); u_axi.arvalid = 1'b0; return;
    end
    @(negedge clk);
    u_axi.arvalid = 1'b0;
    check_eq("r_first", 32'(u_axi.rvalid), 32'd1);
    ok = 1'b1;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] id, input bit rr_toggle);
    logic [31:0] a, exp_d;
    logic [1:0]  exp_r;
    bit ok;
    int n;
    ar_start(addr, len, burst, size, id, ok);
    if (!ok) return;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!u_axi.rvalid && n < 100) begin @(negedge clk); n++; end
      if (!u_axi.rvalid) begin check_eq("r_timeout", 32'd0, 32'd1); return; end
      if (rr_toggle) repeat ($urandom_range(0, 2)) @(negedge clk);
      a = beat_addr(addr, burst, i);
      if (!in_map(a)) begin
        exp_d = 32'd0; exp_r = 2'b11;
      end else if (bad_burst(burst, size)) begin
        exp_d = 32'd0; exp_r = 2'b10;
      end else begin
        exp_d = ref_mem[(a - BASE_ADDR) >> 2]; exp_r = 2'b00;
      end
      check_eq("rdata", u_axi.rdata, exp_d);
      check_eq("rresp", 32'(u_axi.rresp), 32'(exp_r));
      check_eq("rlast", 32'(u_axi.rlast), 32'(i == int'(len)));
      check_eq("rid", 32'(u_axi.rid), 32'(id));
      u_axi.rready = 1'b1;
      @(negedge clk);
      u_axi.rready = 1'b0;
    end
    check_eq("r_done", 32'(u_axi.rvalid), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] dq[$];
  logic [3:0]  sq[$];
  logic [31:0] ta;
  logic [7:0]  tl;
  logic [1:0]  tb_burst;
  bit          ok;

  initial begin
    reset = 1'b1;
    u_axi.awvalid = 0; u_axi.awaddr = 0; u_axi.awlen = 0; u_axi.awsize = 0;
    u_axi.awburst = 0; u_axi.awid = 0; u_axi.wvalid = 0; u_axi.wdata = 0;
    u_axi.wstrb = 0; u_axi.wlast = 0; u_axi.bready = 0; u_axi.arvalid = 0;
    u_axi.araddr = 0; u_axi.arlen = 0; u_axi.arsize = 0; u_axi.arburst = 0;
    u_axi.arid = 0; u_axi.rready = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_awready", 32'(u_axi.awready), 32'd0);
    check_eq("rst_wready", 32'(u_axi.wready), 32'd0);
    check_eq("rst_bvalid", 32'(u_axi.bvalid), 32'd0);
    check_eq("rst_arready", 32'(u_axi.arready), 32'd0);
    check_eq("rst_rvalid", 32'(u_axi.rvalid), 32'd0);
    check_eq("rst_rlast", 32'(u_axi.rlast), 32'd0);
    check_eq("rst_bresp", 32'(u_axi.bresp), 32'd0);
    check_eq("rst_rresp", 32'(u_axi.rresp), 32'd0);
    check_eq("rst_bid", 32'(u_axi.bid), 32'd0);
    check_eq("rst_rid", 32'(u_axi.rid), 32'd0);
    check_eq("rst_rdata", u_axi.rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rel_awready", 32'(u_axi.awready), 32'd1);
    check_eq("rel_arready", 32'(u_axi.arready), 32'd1);

    // Fill the whole memory so every later read has a known expectation.
    for (int b = 0; b < 4; b++) begin
      dq = {}; sq = {};
      for (int i = 0; i < 256; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
      axi_write(BASE_ADDR + 32'(b * 1024), 8'd255, BURST_INCR, 3'd2, 4'(b), dq, sq, 255, 0);
    end

    dq = {32'hDEAD_BEEF}; sq = {4'hF};
    axi_write(32'h10, 8'd0, BURST_INCR, 3'd2, 4'h3, dq, sq, 0, 0);
    axi_read(32'h10, 8'd0, BURST_INCR, 3'd2, 4'h3, 1'b0);
    check_eq("single_ref", ref_mem[4], 32'hDEAD_BEEF);

    dq = {32'd1, 32'd2, 32'd3, 32'd4}; sq = {4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(32'h100, 8'd3, BURST_INCR, 3'd2, 4'h5, dq, sq, 3, 5);
    axi_read(32'h100, 8'd3, BURST_INCR, 3'd2, 4'h6, 1'b1);

    dq = {32'hFFFF_FFFF}; sq = {4'hF};
    axi_write(32'h20, 8'd0, BURST_INCR, 3'd2, 4'h1, dq, sq, 0, 0);
    dq = {32'h1122_3344}; sq = {4'b0101};
    axi_write(32'h20, 8'd0, BURST_INCR, 3'd2, 4'h1, dq, sq, 0, 0);
    check_eq("strb_ref", ref_mem[8], 32'hFF22_FF44);
    axi_read(32'h20, 8'd0, BURST_INCR, 3'd2, 4'h2, 1'b0);

    axi_read(32'h0FFC, 8'd1, BURST_INCR, 3'd2, 4'h7, 1'b0);
    dq = {32'hCAFE_F00D, 32'h1234_5678}; sq = {4'hF, 4'hF};
    axi_write(32'h0FFC, 8'd1, BURST_INCR, 3'd2, 4'h7, dq, sq, 1, 0);
    axi_read(32'h0FFC, 8'd0, BURST_INCR, 3'd2, 4'h7, 1'b0);

    dq = {32'hAAAA_AAAA, 32'hBBBB_BBBB}; sq = {4'hF, 4'hF};
    axi_write(32'h40, 8'd1, BURST_WRAP, 3'd2, 4'h8, dq, sq, 1, 0);
    axi_read(32'h40, 8'd1, BURST_INCR, 3'd2, 4'h8, 1'b0);
    axi_write(32'h80, 8'd1, BURST_INCR, 3'd2, 4'h9, dq, sq, 0, 0);
    axi_read(32'h80, 8'd1, BURST_INCR, 3'd2, 4'h9, 1'b0);
    dq = {32'h5555_5555}; sq = {4'hF};
    axi_write(32'h44, 8'd0, BURST_INCR, 3'd1, 4'hA, dq, sq, 0, 0);
    axi_read(32'h44, 8'd0, BURST_INCR, 3'd1, 4'hA, 1'b0);
    axi_read(32'h44, 8'd0, BURST_WRAP, 3'd2, 4'hA, 1'b0);
    axi_read(32'hFFFF_FFFC, 8'd1, BURST_INCR, 3'd2, 4'hB, 1'b0);

    // Reset in the middle of a 4-beat read.
    ar_start(32'h200, 8'd3, BURST_INCR, 3'd2, 4'hC, ok);
    repeat (2) begin u_axi.rready = 1'b1; @(negedge clk); u_axi.rready = 1'b0; end
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_rvalid", 32'(u_axi.rvalid), 32'd0);
    check_eq("mid_rst_rlast", 32'(u_axi.rlast), 32'd0);
    check_eq("mid_rst_arready", 32'(u_axi.arready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_arready", 32'(u_axi.arready), 32'd1);
    check_eq("post_rst_rvalid", 32'(u_axi.rvalid), 32'd0);
    axi_read(32'h200, 8'd3, BURST_INCR, 3'd2, 4'hD, 1'b1);

    // Concurrent write and read to disjoint regions.
    dq = {}; sq = {};
    for (int i = 0; i < 4; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    fork
      axi_write(32'h300, 8'd3, BURST_INCR, 3'd2, 4'h1, dq, sq, 3, 2);
      axi_read(32'h600, 8'd3, BURST_INCR, 3'd2, 4'h2, 1'b1);
    join

    for (int t = 0; t < 60; t++) begin
      ta = BASE_ADDR + 32'($urandom_range(0, MEM_WORDS - 1) * 4) + 32'($urandom_range(0, 3));
      tl = 8'($urandom_range(0, 7));
      tb_burst = ($urandom_range(0, 1) == 0) ? BURST_FIXED : BURST_INCR;
      if ($urandom_range(0, 1) == 0) begin
        dq = {}; sq = {};
        for (int i = 0; i <= int'(tl); i++) begin
          dq.push_back($urandom); sq.push_back(4'($urandom_range(0, 15)));
        end
        axi_write(ta, tl, tb_burst, 3'd2, 4'($urandom_range(0, 15)), dq, sq, int'(tl),
                  $urandom_range(0, 3));
      end else begin
        axi_read(ta, tl, tb_burst, 3'd2, 4'($urandom_range(0, 15)), 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_mem_slave.md
AXI4_MEM_SLAVE -- requirements
Module: axi4_mem_slave

Interface
REQ-001 Parameter MEM_WORDS, default 1024, depth of the internal 32-bit word memory (4 KiB).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, first byte address decoded by the block.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 axi  axi4_if.slave  n/a  full AXI4 responder port: AW, W, B, AR and R channels, 32-bit data, 4-bit ID, 8-bit len.

Function
REQ-006 The block SHALL be the responder end of axi4_if; read and write paths SHALL run concurrently and independently.
REQ-007 Write FSM states SHALL be W_IDLE, W_DATA, W_RESP; W_IDLE->W_DATA on awvalid&&awready; W_DATA->W_RESP on the beat where beat count equals awlen; W_RESP->W_IDLE on bvalid&&bready.
REQ-008 awready SHALL be 1 only in W_IDLE; wready SHALL be 1 only in W_DATA; bvalid SHALL be 1 only in W_RESP and held until bready.
REQ-009 awaddr, awlen, awsize, awburst, awid SHALL be captured on the AW handshake; bid SHALL equal the captured awid.
REQ-010 Each W handshake SHALL write byte lanes whose wstrb bit is 1; lanes with wstrb bit 0 SHALL be unchanged.
REQ-011 Beat count, not wlast, SHALL end the burst; wlast absent on the last beat or present earlier SHALL yield bresp=2'b10 (SLVERR), with all awlen+1 beats still accepted.
REQ-012 Read FSM states SHALL be R_IDLE, R_DATA; arready=1 only in R_IDLE; R_IDLE->R_DATA on AR handshake; R_DATA->R_IDLE on the R handshake with rlast=1.
REQ-013 First rvalid SHALL assert the cycle after the AR handshake; rvalid, rdata, rresp, rlast, rid SHALL be registered and held stable while rvalid&&!rready.
REQ-014 rlast SHALL be 1 only on beat arlen; rid SHALL equal the captured arid.
REQ-015 Burst addressing: INCR (2'b01) SHALL add 4 per beat; FIXED (2'b00) SHALL repeat the start address; WRAP (2'b10) and 2'b11 SHALL be answered SLVERR for the whole burst, no memory write, rdata=0.
REQ-016 Any size other than 3'b010 SHALL be answered SLVERR as in REQ-015.
REQ-017 Word index SHALL be (addr-BASE_ADDR)>>2, low two address bits ignored; a beat with addr<BASE_ADDR or index>=MEM_WORDS SHALL be DECERR (2'b11): write suppressed, rdata=0, rresp=2'b11 for that beat.
REQ-018 bresp SHALL be the most severe response of any beat (DECERR>SLVERR>OKAY); rresp SHALL be per beat.
REQ-019 Simultaneous write and read to the same word in one cycle SHALL return the pre-write data.
REQ-020 Address arithmetic SHALL be 32-bit unsigned; INCR wrap past 32'hFFFF_FFFC SHALL wrap to 0 and decode as REQ-017.

Reset
REQ-021 While reset=1: awready, wready, bvalid, arready, rvalid, rlast SHALL be 0; bresp, rresp, bid, rid, rdata SHALL be 0; both FSMs SHALL go to IDLE.
REQ-022 awready and arready SHALL first be 1 the cycle after reset deasserts.
REQ-023 Reset mid-burst SHALL abandon the burst without a response; memory contents SHALL NOT be reset.

Structure
REQ-024 Package axi4_pkg SHALL hold the burst constants (FIXED/INCR/WRAP), response constants (OKAY/EXOKAY/SLVERR/DECERR), and the write/read FSM state enums.
REQ-025 One sub-module axi4_burst_addr SHALL compute next address and range/error decode, instantiated once per channel.
REQ-026 Memory SHALL be one array of MEM_WORDS x 32 with one write and one read port.

Verification
REQ-027 Single write 0x10 data 0xDEADBEEF wstrb 4'hF, then read 0x10 -> bresp OKAY, rdata 0xDEADBEEF, rlast=1, rresp OKAY.
REQ-028 INCR write awlen=3 at 0x100 data 1..4 with bready low 5 cycles, then INCR read arlen=3 with rready toggling -> bvalid held, read beats 1,2,3,4, rlast only on 4th.
REQ-029 Write 0x20 = 0xFFFFFFFF, then wstrb 4'b0101 data 0x11223344 -> read 0xFF22FF44.
REQ-030 Read at 0x0FFC arlen=1 (MEM_WORDS=1024) -> beat0 OKAY, beat1 rresp DECERR rdata 0; write same burst -> bresp DECERR, 0x0FFC written.
REQ-031 Write with awburst=WRAP, and write awlen=1 with wlast on beat 0 -> both bresp SLVERR, memory unchanged for WRAP.
REQ-032 Assert reset during beat 2 of a 4-beat read -> next cycle rvalid=0, arready=1 after release, new read completes correctly.
